// File: rtl/lwe_decrypt_stream.sv
// Streaming LWE decryption: x = (b - sum a_i*s_i) mod q, m = round(x*p/q) mod p.
// Optional out_noise port enabled by LWE_DECRYPT_NOISE_OUT_EN.
module lwe_decrypt_stream #(
  parameter int PLAINTEXT_MODULUS  = 64,
  parameter int PLAINTEXT_WIDTH    = 6,
  parameter int CIPHERTEXT_MODULUS = 1024,
  parameter int CIPHERTEXT_WIDTH   = 10,
  parameter int DIMENSION          = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [CIPHERTEXT_WIDTH-1:0] in_a,
  input  logic [CIPHERTEXT_WIDTH-1:0] in_s,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [PLAINTEXT_WIDTH-1:0]  out_plaintext,
`ifdef LWE_DECRYPT_NOISE_OUT_EN
  output logic signed [CIPHERTEXT_WIDTH-1:0] out_noise,
`endif
  output logic                        out_error
);

  localparam int CW    = CIPHERTEXT_WIDTH;
  localparam int PW    = PLAINTEXT_WIDTH;
  localparam int SHIFT = CW - PW;
  localparam int CNT_W = $clog2(DIMENSION + 1);
  localparam logic [CW-1:0] HALF = CW'(1) << (SHIFT - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIMENSION);

  typedef enum logic {ACCUM, OUTPUT} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CW-1:0]    acc;
  logic [CW-1:0]    prod;
  logic [CW-1:0]    x;
  logic [CW-1:0]    rnd;
  logic [PW-1:0]    m;
  logic             fire;
  logic             is_end;
  logic             frame_err;

  // Product is evaluated at CW bits, which keeps only the low half.
  assign prod      = in_a * in_s;
  assign x         = in_a + acc;
  assign rnd       = x + HALF;
  assign m         = rnd[CW-1:SHIFT];
  assign is_end    = (cnt == LAST_CNT);
  assign frame_err = (in_last != is_end);
  assign in_ready  = (state == ACCUM) && !rst_n;
  assign fire      = in_valid && in_ready;

`ifdef LWE_DECRYPT_NOISE_OUT_EN
  logic [CW-1:0] noise;
  assign noise = x - {m, {SHIFT{1'b0}}};
`endif

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state         <= ACCUM;
      cnt           <= '0;
      acc           <= '0;
      out_valid     <= 1'b0;
      out_plaintext <= '0;
      out_error     <= 1'b0;
`ifdef LWE_DECRYPT_NOISE_OUT_EN
      out_noise     <= '0;
`endif
    end else begin
      unique case (state)
        ACCUM: begin
          if (fire) begin
            if (frame_err) begin
              out_plaintext <= '0;
              out_error     <= 1'b1;
`ifdef LWE_DECRYPT_NOISE_OUT_EN
              out_noise     <= '0;
`endif
              out_valid     <= 1'b1;
              state         <= OUTPUT;
            end else if (is_end) begin
              out_plaintext <= m;
              out_error     <= 1'b0;
`ifdef LWE_DECRYPT_NOISE_OUT_EN
              out_noise     <= noise;
`endif
              out_valid     <= 1'b1;
              state         <= OUTPUT;
            end else begin
              acc <= acc - prod;
              cnt <= cnt + 1'b1;
            end
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            state     <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: doc/lwe_decrypt_stream.md
Name: lwe_decrypt_stream

Overview:
- Streaming LWE decryption stage that sits directly downstream of the homomorphic adder.
- Consumes one ciphertext frame per message: DIMENSION beats of (a_i, s_i) pairs, then one b beat.
- Computes x = (b - sum a_i*s_i) mod q and rounds x to the plaintext m = round(x*p/q) mod p.
- Used to check homomorphic results on-chip; valid/ready on both sides.

Parameters:
PLAINTEXT_MODULUS  64  plaintext modulus p; power of two
PLAINTEXT_WIDTH  6  log2(p)
CIPHERTEXT_MODULUS  1024  ciphertext modulus q; power of two, q > p
CIPHERTEXT_WIDTH  10  log2(q)
DIMENSION  4  LWE vector length n; at least 1

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  reset; asynchronous, active-high (asserted = 1)
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid && in_ready
in_a  in  CIPHERTEXT_WIDTH  a_i on beats 0..n-1; b on beat n
in_s  in  CIPHERTEXT_WIDTH  secret-key element s_i; ignored on the b beat
in_last  in  1  upstream end-of-frame marker; expected only on beat n
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_plaintext  out  PLAINTEXT_WIDTH  decrypted m
out_error  out  1  framing error flag for this result

Behaviour:
- Reset values (asynchronous):
  - state = ACCUM, beat counter = 0, accumulator = 0.
  - out_valid = 0, out_plaintext = 0, out_error = 0, in_ready = 0 while reset is held.
- States:
  - ACCUM: in_ready = 1.
  - OUTPUT: in_ready = 0; out_valid = 1; output registers held stable.
- ACCUM, accepted beat with cnt < n and in_last = 0:
  - acc <= (acc - in_a*in_s) mod q, using the low CIPHERTEXT_WIDTH bits of the 2*CIPHERTEXT_WIDTH-bit product.
  - cnt <= cnt + 1.
- ACCUM, accepted beat with cnt == n and in_last = 1:
  - x = (in_a + acc) mod q.
  - out_plaintext <= ((x + q/(2p)) >> (CIPHERTEXT_WIDTH - PLAINTEXT_WIDTH)) mod p, i.e. round half up, with wrap at p.
  - out_error <= 0; go to OUTPUT.
- Framing error: accepted beat where in_last = 1 and cnt < n, or in_last = 0 and cnt == n.
  - out_plaintext <= 0, out_error <= 1; go to OUTPUT.
  - That beat ends the frame.
- Latency: out_valid rises the cycle after the terminating beat is accepted.
- OUTPUT: when out_ready = 1 (handshake complete):
  - acc <= 0, cnt <= 0, out_valid <= 0, return to ACCUM.
  - in_ready returns to 1 the following cycle; no bubble-free overlap is required.
- Throughput: one frame per n+2 cycles when out_ready is held high.
- All arithmetic is unsigned mod q; the accumulator wraps silently, which is not an error.
- in_valid = 0 in ACCUM: state holds, no update.
- Reset asserted mid-frame or mid-OUTPUT: partial frame discarded, pending result dropped, return to reset values.

Optional Feature:
- Macro: LWE_DECRYPT_NOISE_OUT_EN
- Defined:
  - Adds output port out_noise, signed, CIPHERTEXT_WIDTH bits, registered together with out_plaintext.
  - out_noise = (x - m*(q/p)) mod q, interpreted as two's complement; range [-q/(2p), q/(2p)-1].
  - On a framing error out_noise = 0; reset value 0.
- Undefined: port absent; behaviour otherwise identical.

Test Plan (DIMENSION=4, q=1024, p=64, so q/p=16):
- All a=0, s arbitrary, b=80 -> out_plaintext=5, out_error=0, out_valid asserts 1 cycle after the b beat; with NOISE_OUT_EN, out_noise=0.
- Rounding: b=87 -> 5 (noise +7); b=88 -> 6 (noise -8); b=1016 -> 0 (wrap at p).
- Accumulator wrap: a=(1,0,0,0), s=(1,5,5,5), b=0 -> x=1023 -> out_plaintext=0; a=(3,2,0,0), s=(512,512,0,0), b=32 -> x=544 -> out_plaintext=34.
- Backpressure: out_ready low for 3 cycles after out_valid -> out_valid, out_plaintext, out_error held, in_ready=0 throughout; handshake on cycle 4, in_ready=1 on cycle 5.
- Framing: in_last on beat 2 -> out_error=1, out_plaintext=0; missing in_last on beat 4 -> out_error=1; the next well-formed frame with b=160 -> out_plaintext=10, out_error=0.
- Reset: assert rst_n after beat 2 of a frame -> outputs return to reset values immediately; a fresh frame with b=48 -> out_plaintext=3.
